// File: rtl/sprite_pkg.sv
// sprite_pkg: sprite-state RAM address map, field offsets and writer state encoding shared by both ends
package sprite_pkg;
   localparam logic [15:0] SPRITE_BASE = 16'h00C8;
   localparam int MARIO_X   = 0;
   localparam int MARIO_Y   = 1;
   localparam int MARIO_M   = 2;
   localparam int OBS_X     = 3;
   localparam int OBS_Y     = 4;
   localparam int OBS_M     = 5;
   localparam int NUM_WORDS = 6;
   localparam int GLYPH_W   = 32;
   localparam int GLYPH_H   = 32;
   localparam int X_MAX     = 640 - GLYPH_W;
   localparam int Y_MAX     = 480 - GLYPH_H;

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WRITE} state_t;

   function automatic int unsigned clamp(input int unsigned v, input int unsigned m);
      return v > m ? m : v;
   endfunction
endpackage

// File: rtl/sync_fall_detect.sv
// sync_fall_detect: registers a level and flags its high-to-low transition; the register resets high
module sync_fall_detect (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic fall
);
   logic in_q, in_d;

   always_comb in_d = in;

   always_ff @(posedge clk) in_q <= reset ? 1'b1 : in_d;

   assign fall = in_q & ~in;
endmodule

// File: rtl/sprite_state_writer.sv
// sprite_state_writer: latches clamped sprite snapshots and copies them to system RAM in the vsync-low window
module sprite_state_writer
   import sprite_pkg::*;
#(
   parameter int SYS_DATA_WIDTH = 18,
   parameter int SYS_ADDR_WIDTH = 16,
   parameter int POS_WIDTH      = 10,
   parameter int SEL_WIDTH      = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      vsync,
   input  logic                      upd_valid,
   output logic                      upd_ready,
   input  logic [POS_WIDTH-1:0]      mario_x,
   input  logic [POS_WIDTH-1:0]      mario_y,
   input  logic [POS_WIDTH-1:0]      obs_x,
   input  logic [POS_WIDTH-1:0]      obs_y,
   input  logic [SEL_WIDTH-1:0]      mario_m,
   input  logic [SEL_WIDTH-1:0]      obs_m,
   output logic                      mem_we,
   output logic [SYS_ADDR_WIDTH-1:0] mem_addr,
   output logic [SYS_DATA_WIDTH-1:0] mem_wdata,
   output logic                      write_done,
   output logic [15:0]               frame_count
);
   typedef logic [SYS_DATA_WIDTH-1:0] word_t;

   state_t                    state_q, state_d;
   logic [2:0]                idx_q, idx_d;
   word_t                     snap_q [NUM_WORDS];
   word_t                     snap_d [NUM_WORDS];
   word_t                     in_w   [NUM_WORDS];
   logic                      mem_we_q, mem_we_d;
   logic [SYS_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   word_t                     mem_wdata_q, mem_wdata_d;
   logic                      write_done_q, write_done_d;
   logic [15:0]               frame_count_q, frame_count_d;
   logic                      fall, accept, last;

   sync_fall_detect u_vsync (
      .clk  (clk),
      .reset(reset),
      .in   (vsync),
      .fall (fall)
   );

   assign upd_ready = ~reset & (state_q != S_WRITE);
   assign accept    = upd_valid & upd_ready;
   assign last      = idx_q == 3'(NUM_WORDS - 1);

   always_comb begin
      in_w[MARIO_X] = word_t'(clamp(32'(mario_x), X_MAX));
      in_w[MARIO_Y] = word_t'(clamp(32'(mario_y), Y_MAX));
      in_w[MARIO_M] = word_t'(mario_m);
      in_w[OBS_X]   = word_t'(clamp(32'(obs_x), X_MAX));
      in_w[OBS_Y]   = word_t'(clamp(32'(obs_y), Y_MAX));
      in_w[OBS_M]   = word_t'(obs_m);
   end

   // Outputs are computed from the next state so each write lands the cycle after its decision
   always_comb begin
      snap_d  = accept ? in_w : snap_q;
      state_d = state_q;
      idx_d   = idx_q;
      if (state_q == S_IDLE && accept) state_d = S_ARMED;
      else if (state_q == S_ARMED && fall) begin
         state_d = S_WRITE;
         idx_d   = '0;
      end else if (state_q == S_WRITE) begin
         state_d = last ? S_IDLE : S_WRITE;
         idx_d   = last ? 3'd0 : idx_q + 3'd1;
      end
      mem_we_d      = state_d == S_WRITE;
      mem_addr_d    = mem_we_d ? SYS_ADDR_WIDTH'(SPRITE_BASE) + SYS_ADDR_WIDTH'(idx_d) : mem_addr_q;
      mem_wdata_d   = mem_we_d ? snap_d[idx_d] : mem_wdata_q;
      write_done_d  = mem_we_d && idx_d == 3'(NUM_WORDS - 1);
      frame_count_d = frame_count_q + 16'(fall);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         snap_q        <= '{default: '0};
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         write_done_q  <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         snap_q        <= snap_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         write_done_q  <= write_done_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign write_done  = write_done_q;
   assign frame_count = frame_count_q;
endmodule

// File: tb/tb_sprite_state_writer.sv
// tb_sprite_state_writer: directed snapshots checked every cycle against a write-queue model plus literal expectations
module tb_sprite_state_writer;
   logic        clk = 0, reset = 1, vsync = 1, upd_valid = 0;
   logic [9:0]  mario_x = 0, mario_y = 0, obs_x = 0, obs_y = 0;
   logic [2:0]  mario_m = 0, obs_m = 0;
   logic        upd_ready, mem_we, write_done;
   logic [15:0] mem_addr, frame_count;
   logic [17:0] mem_wdata;

   sprite_state_writer dut (
      .clk(clk), .reset(reset), .vsync(vsync), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .mario_x(mario_x), .mario_y(mario_y), .obs_x(obs_x), .obs_y(obs_y),
      .mario_m(mario_m), .obs_m(obs_m), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .write_done(write_done), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int mn(input int a, input int b);
      return a < b ? a : b;
   endfunction

   // Model: a pending snapshot plus a queue of RAM writes still to appear on the bus
   int m_fc, m_pv[6], m_addr, m_data, q_addr[$], q_data[$], log_a[$], log_d[$], low_cnt;
   bit m_vs, m_pend, m_we, m_done, f_m, rdy_m, was_m;

   always @(posedge clk) begin
      if (reset) begin
         m_vs = 1; m_fc = 0; m_pend = 0; m_we = 0; m_done = 0; m_addr = 0; m_data = 0;
         q_addr.delete(); q_data.delete();
      end else begin
         f_m = m_vs && !vsync;
         m_vs = vsync;
         rdy_m = !m_we;
         was_m = m_pend;
         if (upd_valid && rdy_m) begin
            m_pend = 1;
            m_pv = '{mn(mario_x, 608), mn(mario_y, 448), mario_m, mn(obs_x, 608), mn(obs_y, 448), obs_m};
         end
         if (f_m) m_fc = (m_fc + 1) % 65536;
         if (f_m && was_m && rdy_m) begin
            for (int i = 0; i < 6; i++) begin
               q_addr.push_back(200 + i);
               q_data.push_back(m_pv[i]);
            end
            m_pend = 0;
         end
         if (q_addr.size() > 0) begin
            m_we = 1;
            m_addr = q_addr.pop_front();
            m_data = q_data.pop_front();
            m_done = q_addr.size() == 0;
         end else begin
            m_we = 0;
            m_done = 0;
         end
      end
      #1;
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_data);
      chk("write_done", write_done, m_done);
      chk("frame_count", frame_count, m_fc);
      chk("upd_ready", upd_ready, int'(!reset && !m_we));
      if (mem_we) begin
         log_a.push_back(mem_addr);
         log_d.push_back(mem_wdata);
      end
      if (!upd_ready) low_cnt++;
   end

   task automatic offer(input int mx, my, mm, ox, oy, om);
      mario_x = 10'(mx); mario_y = 10'(my); mario_m = 3'(mm);
      obs_x = 10'(ox); obs_y = 10'(oy); obs_m = 3'(om);
      upd_valid = 1;
      @(negedge clk);
      upd_valid = 0;
   endtask

   task automatic vfall();
      vsync = 0;
      repeat (8) @(negedge clk);
      vsync = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask

   initial begin
      int e1[6];
      e1 = '{100, 200, 1, 300, 50, 2};
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("rst_fc", frame_count, 0);
      chk("rst_ready", upd_ready, 1);
      chk("rst_we", mem_we, 0);

      clear_log();
      offer(100, 200, 1, 300, 50, 2);
      vfall();
      chk("t1_count", log_a.size(), 6);
      for (int i = 0; i < 6 && i < log_a.size(); i++) begin
         chk("t1_addr", log_a[i], 200 + i);
         chk("t1_data", log_d[i], e1[i]);
      end
      chk("t1_fc", frame_count, 1);

      clear_log();
      offer(700, 5, 3, 10, 479, 7);
      vfall();
      chk("t2_count", log_a.size(), 6);
      if (log_d.size() == 6) begin
         chk("t2_x_clamp", log_d[0], 608);
         chk("t2_sel", log_d[2], 3);
         chk("t2_y_clamp", log_d[4], 448);
      end
      clear_log();
      offer(608, 448, 0, 0, 0, 0);
      vfall();
      chk("t2b_count", log_a.size(), 6);
      if (log_d.size() == 6) chk("t2b_x_exact", log_d[0], 608);

      clear_log();
      offer(10, 1, 1, 1, 1, 1);
      offer(20, 1, 1, 1, 1, 1);
      vfall();
      chk("t3_count", log_a.size(), 6);
      if (log_d.size() == 6) chk("t3_latest", log_d[0], 20);
      clear_log();
      vfall();
      chk("t3_idle_fall", log_a.size(), 0);
      chk("t3_fc", frame_count, 5);

      offer(1, 2, 3, 4, 5, 6);
      clear_log();
      low_cnt = 0;
      mario_x = 33;
      upd_valid = 1;
      vsync = 0;
      @(negedge clk);
      upd_valid = 0;
      repeat (8) @(negedge clk);
      vsync = 1;
      repeat (2) @(negedge clk);
      chk("t4_count", log_a.size(), 6);
      if (log_d.size() == 6) begin
         chk("t4_coincident", log_d[0], 33);
         chk("t4_obs_m", log_d[5], 6);
      end
      chk("t4_ready_low", low_cnt, 6);

      offer(7, 8, 1, 9, 10, 2);
      clear_log();
      vsync = 0;
      repeat (3) @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      vsync = 1;
      repeat (3) @(negedge clk);
      chk("t5_writes", log_a.size(), 3);
      chk("t5_fc", frame_count, 0);
      chk("t5_ready", upd_ready, 1);
      chk("t5_we", mem_we, 0);

      force dut.frame_count_q = 16'hFFFF;
      m_fc = 65535;
      @(negedge clk);
      release dut.frame_count_q;
      chk("t6_preload", frame_count, 65535);
      vsync = 0;
      @(negedge clk);
      chk("t6_wrap", frame_count, 0);
      vsync = 1;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/sprite_state_writer.md
# sprite_state_writer

Writer side of the sprite-state words in shared system RAM that the VGA glyph address path reads at the start of every frame. Accepts a sprite-state snapshot from game logic over a valid/ready handshake, clamps it to the displayable area, and writes it as six consecutive words at SPRITE_BASE..SPRITE_BASE+5 only during the vsync-low window. The display side therefore always latches a self-consistent set of values. Also maintains a free-running frame counter for game-logic pacing.

## Interface
- SYS_DATA_WIDTH, 18, width of a system RAM word
- SYS_ADDR_WIDTH, 16, system RAM address width
- POS_WIDTH, 10, width of x/y positions
- SEL_WIDTH, 3, width of glyph/movement select fields
- SPRITE_BASE, 16'h00C8, address of the first sprite word
- X_MAX, 608, largest legal x (640 - 32-pixel glyph)
- Y_MAX, 448, largest legal y (480 - 32-pixel glyph)
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- vsync  in  1  VGA vertical sync, active-low
- upd_valid  in  1  snapshot offered
- upd_ready  out  1  snapshot can be accepted
- mario_x, mario_y, obs_x, obs_y  in  POS_WIDTH each  positions
- mario_m, obs_m  in  SEL_WIDTH each  glyph selects
- mem_we  out  1  RAM write enable
- mem_addr  out  SYS_ADDR_WIDTH  RAM write address
- mem_wdata  out  SYS_DATA_WIDTH  RAM write data
- write_done  out  1  one-cycle pulse after the sixth word is written
- frame_count  out  16  count of vsync falling edges

## Operation
- Edge detect: vsync_d registers vsync, reset value 1. fall = vsync_d & ~vsync.
- States:
  - IDLE: no pending snapshot.
  - ARMED: snapshot pending.
  - WRITE: 3-bit index 0..5.
- upd_ready = 1 in IDLE and ARMED, 0 in WRITE and during reset.
- Accept (upd_valid & upd_ready):
  - Snapshot registers load the clamped values.
  - IDLE→ARMED.
  - In ARMED, the new snapshot overwrites the pending one (latest wins).
- Clamp: x = min(in, X_MAX), y = min(in, Y_MAX). Select fields pass through unchanged. All fields are zero-extended to SYS_DATA_WIDTH.
- ARMED & fall → WRITE, index 0.
  - If an accept occurs in the same cycle, the write uses the newly accepted snapshot.
- IDLE & fall: no writes.
- WRITE, index i: mem_we=1, mem_addr=SPRITE_BASE+i.
  - Data order: mario_x, mario_y, mario_m, obs_x, obs_y, obs_m.
  - At i=5: write_done=1 and the state returns to IDLE.
- vsync rising during WRITE does not abort the sequence. The low window is ≥2 lines, so this cannot occur legally.
- frame_count increments on every fall in any state and wraps 0xFFFF→0.
- Reset values:
  - State IDLE, pending cleared, snapshot 0, vsync_d=1.
  - mem_we=0, mem_addr=0, mem_wdata=0, write_done=0, frame_count=0.
- Reset mid-write: mem_we is 0 from the next cycle. Remaining words are not written.

## Timing
- All outputs are registered.
- Cycle T: vsync sampled low (vsync_d=1).
  - T+1: state WRITE. mem_we high for T+1..T+6 at addresses C8..CD.
  - T+6: write_done pulses, coincident with the last write. State is IDLE on T+7.
- Accept to earliest write: at least 2 cycles, bounded by the next vsync fall.
- frame_count updates at T+1.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Structure
- Shared package sprite_pkg: SPRITE_BASE, per-field offsets (MARIO_X=0 … OBS_M=5), X_MAX, Y_MAX, glyph width/height 32, state enum.
- The display-side reader imports the same package so both ends agree on the address map.
- One sub-module: sync_fall_detect (vsync register + falling-edge pulse, reset-to-1).

## Test plan
- Reset, then offer (100,200,1,300,50,2), then drive vsync low → six writes at C8..CD with 100,200,1,300,50,2. write_done on the 6th. frame_count=1.
- Offer mario_x=700, obs_y=479 → written 608 and 448. mario_x=608 exact → 608.
- Two accepts before one vsync fall (x=10, then x=20) → only x=20 written. A second fall with nothing pending produces no writes.
- Accept coincident with the vsync fall in ARMED → the new snapshot is written. upd_ready low for exactly 6 cycles.
- Assert reset after the 3rd write → mem_we low next cycle, no writes to CB..CD, frame_count=0, upd_ready high.
- Preload frame_count path with 65535 falls, then one more → frame_count wraps to 0.
